// File: rtl/seq_multiplier_radix.sv
// Iterative N x N -> 2N multiplier, K multiplier bits retired per clock.
// Operands are folded to magnitudes on load; sign is reapplied on completion.
module seq_multiplier_radix #(
    parameter int N = 32,
    parameter int K = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           recieved,
    input  logic           signed_a,
    input  logic           signed_b,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           done,
    output logic           init,
    output logic           busy,
    output logic [2*N-1:0] C
);

    localparam int STEPS = N / K;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    if ((K < 1) || (N % K != 0)) begin : g_bad_radix
        $error("seq_multiplier_radix: N must be a multiple of K");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    m;
    logic [N-1:0]    q;
    logic [N+K-1:0]  acc;
    logic            neg;

    logic            a_neg;
    logic            b_neg;
    logic [N-1:0]    a_mag;
    logic [N-1:0]    b_mag;
    logic [N+K-1:0]  partial;
    logic [2*N+K-1:0] sum;
    logic [2*N+K-1:0] step;
    logic [2*N-1:0]  prod;
    logic [2*N-1:0]  prod_signed;

    // Magnitude of the most negative value still fits in N unsigned bits.
    always_comb begin
        a_neg = signed_a & A[N-1];
        b_neg = signed_b & B[N-1];
        a_mag = a_neg ? (~A + 1'b1) : A;
        b_mag = b_neg ? (~B + 1'b1) : B;
    end

    always_comb begin
        partial     = {{K{1'b0}}, m} * {{N{1'b0}}, q[K-1:0]};
        sum         = {acc, q} + {partial, {N{1'b0}}};
        step        = sum >> K;
        prod        = step[2*N-1:0];
        prod_signed = neg ? (~prod + 1'b1) : prod;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        init    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state)
            S_IDLE: begin
                init = 1'b1;
                if (load) begin
                    state_n = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (recieved) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            m   <= '0;
            q   <= '0;
            acc <= '0;
            neg <= 1'b0;
            C   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (load) begin
                        m   <= a_mag;
                        q   <= b_mag;
                        neg <= a_neg ^ b_neg;
                        acc <= '0;
                        cnt <= CW'(STEPS - 1);
                    end
                end
                S_CALC: begin
                    acc <= step[2*N+K-1:N];
                    q   <= step[N-1:0];
                    // The final step's result goes straight to C.
                    if (cnt == '0) begin
                        C <= prod_signed;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
